// File: rtl/note_lookup_bsearch_if.sv
// Handshake, result and configuration signals of the note lookup block.
// The producer/consumer side uses master; the lookup block uses slave.
interface note_lookup_bsearch_if #(
  parameter int BIN_W  = 13,
  parameter int NOTE_W = 5,
  parameter int ADDR_W = 5
);
  logic [BIN_W-1:0]  bin_in;
  logic              in_valid;
  logic              in_ready;
  logic [NOTE_W-1:0] note_index;
  logic              hit;
  logic              out_valid;
  logic              out_ready;
  logic              cfg_we;
  logic [ADDR_W-1:0] cfg_addr;
  logic [BIN_W-1:0]  cfg_data;

  modport master (
    output bin_in, in_valid, out_ready, cfg_we, cfg_addr, cfg_data,
    input  in_ready, note_index, hit, out_valid
  );

  modport slave (
    input  bin_in, in_valid, out_ready, cfg_we, cfg_addr, cfg_data,
    output in_ready, note_index, hit, out_valid
  );
endinterface

// File: rtl/note_lookup_bsearch.sv
// Maps an FFT peak bin to a note index by binary search over a programmable,
// strictly ascending boundary table b[0..NUM_NOTES] (note k: b[k] <= bin < b[k+1]).
module note_lookup_bsearch #(
  parameter int BIN_W     = 13,
  parameter int NUM_NOTES = 22,
  parameter int NOTE_W    = 5,
  parameter int ADDR_W    = 5,
  parameter int HOLD_MISS = 0,
  parameter logic [BIN_W-1:0] INIT_TABLE [NUM_NOTES+1] = '{
    BIN_W'(126), BIN_W'(133), BIN_W'(141), BIN_W'(149), BIN_W'(158), BIN_W'(168),
    BIN_W'(178), BIN_W'(188), BIN_W'(200), BIN_W'(212), BIN_W'(224), BIN_W'(238),
    BIN_W'(252), BIN_W'(267), BIN_W'(283), BIN_W'(299), BIN_W'(317), BIN_W'(336),
    BIN_W'(356), BIN_W'(377), BIN_W'(400), BIN_W'(424), BIN_W'(449)
  }
) (
  input logic                  clk_in,
  input logic                  rst_in,
  note_lookup_bsearch_if.slave bus
);

  localparam int STEPS  = $clog2(NUM_NOTES);
  localparam int STEP_W = (STEPS < 1) ? 1 : $clog2(STEPS + 1);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_NOTES);
  localparam logic [ADDR_W-1:0] ONE_ADDR  = ADDR_W'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [BIN_W-1:0]  bin_q, bin_d;
  logic [ADDR_W-1:0] lo_q, lo_d;
  logic [ADDR_W-1:0] hi_q, hi_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [NOTE_W-1:0] note_q, note_d;
  logic              hit_q, hit_d;
  logic [NOTE_W-1:0] last_q, last_d;

  logic [BIN_W-1:0]  bnd_q [NUM_NOTES+1] = INIT_TABLE;
  logic [ADDR_W:0]   mid_sum;
  logic [ADDR_W-1:0] mid;
  logic              is_miss;
  logic              cfg_commit;

  assign mid_sum    = {1'b0, lo_q} + {1'b0, hi_q};
  assign mid        = mid_sum[ADDR_W:1];
  assign is_miss    = (bin_q < bnd_q[0]) || (bin_q >= bnd_q[NUM_NOTES]);
  assign cfg_commit = bus.cfg_we && (state_q == IDLE) && (bus.cfg_addr <= LAST_ADDR);

  // NOTE: the boundary table is storage, not control state, so it has no reset;
  // it keeps its contents across rst_in and only changes through the config port.
  always_ff @(posedge clk_in) begin
    if (cfg_commit) begin
      bnd_q[bus.cfg_addr] <= bus.cfg_data;
    end
  end

  // NOTE: every variable gets its hold value first so that no path through the
  // case leaves one unassigned; otherwise this block would infer latches.
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    step_d  = step_q;
    note_d  = note_q;
    hit_d   = hit_q;
    last_d  = last_q;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          bin_d   = bus.bin_in;
          lo_d    = '0;
          hi_d    = LAST_ADDR;
          step_d  = '0;
          state_d = SEARCH;
        end
      end

      SEARCH: begin
        if (is_miss) begin
          hit_d   = 1'b0;
          note_d  = (HOLD_MISS != 0) ? last_q : '0;
          state_d = DONE;
        end else if (step_q == LAST_STEP) begin
          hit_d   = 1'b1;
          note_d  = NOTE_W'(lo_q);
          last_d  = NOTE_W'(lo_q);
          state_d = DONE;
        end else begin
          // A fixed number of halving steps gives a constant hit latency; once the
          // interval has shrunk to one note the remaining steps leave lo/hi alone.
          step_d = step_q + 1'b1;
          if ((hi_q - lo_q) > ONE_ADDR) begin
            if (bin_q >= bnd_q[mid]) begin
              lo_d = mid;
            end else begin
              hi_d = mid;
            end
          end
        end
      end

      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
      bin_q   <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      step_q  <= '0;
      note_q  <= '0;
      hit_q   <= 1'b0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      step_q  <= step_d;
      note_q  <= note_d;
      hit_q   <= hit_d;
      last_q  <= last_d;
    end
  end

  assign bus.in_ready   = (state_q == IDLE);
  assign bus.out_valid  = (state_q == DONE);
  assign bus.note_index = note_q;
  assign bus.hit        = hit_q;

endmodule
